// File: rtl/blink_load_if.sv
`default_nettype none
// ============================================================================
// Module      : blink_load_if
// Description : Operand word stream into the blink_load loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface blink_load_if #(
    parameter int WORD = 32
) ();
    logic [WORD-1:0] s_data;
    logic            s_valid;
    logic            s_ready;
    logic            rekey;
    logic            enc_in;

    modport master (
        output s_data,
        output s_valid,
        output rekey,
        output enc_in,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  rekey,
        input  enc_in,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/blink_load.sv
`default_nettype none
// ============================================================================
// Module      : blink_load
// Description : Word-serial operand loader and run sequencer for a tweakable
//               block cipher (K0, K1, T, P fields, fixed-latency run).
// Revision    : 1.0 - initial release
// ============================================================================
module blink_load #(
    parameter int WORD    = 32,
    parameter int LATENCY = 20
) (
    input  wire logic          clk,
    input  wire logic          rst,
    blink_load_if.slave        s,
    output logic               enc,
    output logic [1279:0]      K0,
    output logic [765:0]       K1,
    output logic [255:0]       T,
    output logic [127:0]       P,
    output logic               start,
    output logic               busy,
    output logic               done,
    output logic               key_valid
);

    localparam int c_k0_words = 40;
    localparam int c_k1_words = 24;
    localparam int c_t_words  = 8;
    localparam int c_p_words  = 4;
    localparam int c_k1_bits  = 766;
    localparam int c_k1_tail  = c_k1_bits - (c_k1_words - 1) * WORD;
    localparam int c_cw       = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_K0 = 3'd1,
        LOAD_K1 = 3'd2,
        LOAD_T  = 3'd3,
        LOAD_P  = 3'd4,
        RUN     = 3'd5
    } state_t;

    state_t               r_state;
    logic [5:0]           r_idx;
    logic [c_cw-1:0]      r_cnt;
    logic                 r_ready;
    logic                 r_enc;
    logic [1279:0]        r_k0;
    logic [c_k1_bits-1:0] r_k1;
    logic [255:0]         r_t;
    logic [127:0]         r_p;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_key_valid;
    logic                 w_xfer;

    assign w_xfer    = s.s_valid & r_ready;
    assign s.s_ready = r_ready;
    assign enc       = r_enc;
    assign K0        = r_k0;
    assign K1        = r_k1;
    assign T         = r_t;
    assign P         = r_p;
    assign start     = r_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign key_valid = r_key_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_enc       <= 1'b0;
            r_k0        <= '0;
            r_k1        <= '0;
            r_t         <= '0;
            r_p         <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Deciding the frame shape costs one bubble cycle; the
                    // presented word is only taken once a LOAD state is entered.
                    if (s.s_valid) begin
                        r_idx   <= '0;
                        r_ready <= 1'b1;
                        if (s.rekey || !r_key_valid) begin
                            r_state     <= LOAD_K0;
                            r_key_valid <= 1'b0;
                        end else begin
                            r_state <= LOAD_T;
                        end
                    end
                end
                LOAD_K0: begin
                    if (w_xfer) begin
                        for (int i = 0; i < c_k0_words; i++) begin
                            if (r_idx == 6'(i)) r_k0[i*WORD +: WORD] <= s.s_data;
                        end
                        if (r_idx == 6'(c_k0_words - 1)) begin
                            r_idx   <= '0;
                            r_state <= LOAD_K1;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                LOAD_K1: begin
                    if (w_xfer) begin
                        for (int i = 0; i < c_k1_words - 1; i++) begin
                            if (r_idx == 6'(i)) r_k1[i*WORD +: WORD] <= s.s_data;
                        end
                        // The key block is not word aligned: the last word's top bits drop.
                        if (r_idx == 6'(c_k1_words - 1)) begin
                            r_k1[c_k1_bits-1 -: c_k1_tail] <= s.s_data[c_k1_tail-1:0];
                            r_idx       <= '0;
                            r_key_valid <= 1'b1;
                            r_state     <= LOAD_T;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                LOAD_T: begin
                    if (w_xfer) begin
                        for (int i = 0; i < c_t_words; i++) begin
                            if (r_idx == 6'(i)) r_t[i*WORD +: WORD] <= s.s_data;
                        end
                        if (r_idx == 6'(c_t_words - 1)) begin
                            r_idx   <= '0;
                            r_state <= LOAD_P;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                LOAD_P: begin
                    if (w_xfer) begin
                        for (int i = 0; i < c_p_words; i++) begin
                            if (r_idx == 6'(i)) r_p[i*WORD +: WORD] <= s.s_data;
                        end
                        if (r_idx == 6'(c_p_words - 1)) begin
                            r_idx   <= '0;
                            r_enc   <= s.enc_in;
                            r_ready <= 1'b0;
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= c_cw'(LATENCY);
                            r_state <= RUN;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                RUN: begin
                    // done is raised on the edge where the count reaches zero,
                    // landing exactly LATENCY cycles after the start cycle.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cw'(1);
                        if (r_cnt == c_cw'(1)) r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blink_load.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_load
// Description : Directed bench for blink_load (LATENCY=20 and LATENCY=1 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_load;

    logic clk = 1'b0;
    logic rst;
    logic en1;
    always #5 clk = ~clk;

    blink_load_if #(.WORD(32)) if0 ();
    blink_load_if #(.WORD(32)) if1 ();

    // The LATENCY=1 copy sees the same stream, gated so it can be kept idle.
    assign if1.s_data  = if0.s_data;
    assign if1.s_valid = if0.s_valid & en1;
    assign if1.rekey   = if0.rekey;
    assign if1.enc_in  = if0.enc_in;

    logic          enc0, start0, busy0, done0, kv0;
    logic [1279:0] k0_0;
    logic [765:0]  k1_0;
    logic [255:0]  t0;
    logic [127:0]  p0;
    logic          enc1, start1, busy1, done1, kv1;
    logic [1279:0] k0_1;
    logic [765:0]  k1_1;
    logic [255:0]  t1;
    logic [127:0]  p1;

    blink_load #(.WORD(32), .LATENCY(20)) dut0 (
        .clk(clk), .rst(rst), .s(if0.slave), .enc(enc0),
        .K0(k0_0), .K1(k1_0), .T(t0), .P(p0),
        .start(start0), .busy(busy0), .done(done0), .key_valid(kv0)
    );

    blink_load #(.WORD(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .s(if1.slave), .enc(enc1),
        .K0(k0_1), .K1(k1_1), .T(t1), .P(p1),
        .start(start1), .busy(busy1), .done(done1), .key_valid(kv1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [1279:0] ref_k0;
    logic [765:0]  ref_k1;
    logic [255:0]  ref_t;
    logic [127:0]  ref_p;

    // Words are presented back-to-back (or with a dead cycle before each odd
    // word when gap=1); each word waits for its own transfer edge.
    task automatic send_frame(input bit rk, input bit en, input int base,
                              input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) begin
                if0.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            if0.s_valid = 1'b1;
            if0.s_data  = 32'(base + i);
            if0.rekey   = rk;
            if0.enc_in  = (i == n - 1) ? en : ~en;
            begin
                bit got = 1'b0;
                int tries = 0;
                while (!got && tries < 10) begin
                    got = if0.s_ready;
                    @(posedge clk); #1;
                    tries++;
                end
                if (!got) begin
                    n_chk++; n_fail++;
                    $display("FAIL xfer_timeout word %0d: s_ready stayed %0b, required 1", i, if0.s_ready);
                end
            end
            if0.s_valid = 1'b0;
        end
    endtask

    task automatic run0(input bit hold_valid, output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        if (hold_valid) begin
            en1 = 1'b0;
            if0.s_valid = 1'b1;
            if0.s_data  = 32'hDEAD_BEEF;
        end
        while (!done0 && n < 100) begin
            if (if0.s_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if0.s_valid = 1'b0;
        en1 = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({start0, busy0, done0, kv0, enc0, if0.s_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 000000", {start0, busy0, done0, kv0, enc0, if0.s_ready});
        end
        n_chk++;
        if ((|k0_0) || (|k1_0) || (|t0) || (|p0)) begin
            n_fail++;
            $display("FAIL reset_data: got nonzero operands (K0[31:0]=%h T[31:0]=%h), required 0", k0_0[31:0], t0[31:0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_frame;
        int n;
        bit rs;
        for (int i = 0; i < 40; i++) ref_k0[i*32 +: 32] = 32'(i);
        for (int i = 0; i < 23; i++) ref_k1[i*32 +: 32] = 32'(40 + i);
        ref_k1[765:736] = 30'd63;
        for (int i = 0; i < 8; i++) ref_t[i*32 +: 32] = 32'(64 + i);
        for (int i = 0; i < 4; i++) ref_p[i*32 +: 32] = 32'(72 + i);
        send_frame(1'b1, 1'b1, 0, 76, 1'b0);
        n_chk++;
        if ({start0, busy0} !== 2'b11) begin
            n_fail++; $display("FAIL full_start: start,busy=%b, required 11", {start0, busy0});
        end
        n_chk++;
        if (k0_0[31:0] !== 32'd0 || k1_0[31:0] !== 32'd40) begin
            n_fail++; $display("FAIL full_word0: K0[31:0]=%0d K1[31:0]=%0d, required 0 and 40", k0_0[31:0], k1_0[31:0]);
        end
        n_chk++;
        if (k1_0[765:736] !== 30'd63) begin
            n_fail++; $display("FAIL full_k1_top: got %h, required %h", k1_0[765:736], 30'd63);
        end
        n_chk++;
        if (t0[31:0] !== 32'd64 || p0[127:96] !== 32'd75) begin
            n_fail++; $display("FAIL full_tp: T[31:0]=%0d P[127:96]=%0d, required 64 and 75", t0[31:0], p0[127:96]);
        end
        n_chk++;
        if (k0_0 !== ref_k0 || k1_0 !== ref_k1 || t0 !== ref_t || p0 !== ref_p) begin
            n_fail++; $display("FAIL full_operands: K0[1279:1248]=%0d P[31:0]=%0d, required 39 and 72", k0_0[1279:1248], p0[31:0]);
        end
        n_chk++;
        if ({enc0, kv0} !== 2'b11) begin
            n_fail++; $display("FAIL full_enc_kv: enc,key_valid=%b, required 11", {enc0, kv0});
        end
        run0(1'b0, n, rs);
        n_chk++;
        if (n != 20) begin
            n_fail++; $display("FAIL full_latency: done after %0d cycles, required 20", n);
        end
        n_chk++;
        if (busy0 !== 1'b1 || k0_0 !== ref_k0 || p0 !== ref_p || enc0 !== 1'b1) begin
            n_fail++; $display("FAIL full_hold_at_done: busy=%b enc=%b, required busy=1 enc=1 operands unchanged", busy0, enc0);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({busy0, done0} !== 2'b00) begin
            n_fail++; $display("FAIL full_after_done: busy,done=%b, required 00", {busy0, done0});
        end
    endtask

    task automatic test_short_frame;
        int n;
        bit rs;
        send_frame(1'b0, 1'b0, 100, 12, 1'b0);
        n_chk++;
        if ({start0, kv0, enc0} !== 3'b110) begin
            n_fail++; $display("FAIL short_start: start,key_valid,enc=%b, required 110", {start0, kv0, enc0});
        end
        n_chk++;
        if (k0_0 !== ref_k0 || k1_0 !== ref_k1) begin
            n_fail++; $display("FAIL short_key_kept: K0[31:0]=%0d K1[31:0]=%0d, required 0 and 40", k0_0[31:0], k1_0[31:0]);
        end
        n_chk++;
        if (t0[31:0] !== 32'd100 || t0[255:224] !== 32'd107 || p0[31:0] !== 32'd108 || p0[127:96] !== 32'd111) begin
            n_fail++; $display("FAIL short_tp: T0=%0d T7=%0d P0=%0d P3=%0d, required 100 107 108 111",
                               t0[31:0], t0[255:224], p0[31:0], p0[127:96]);
        end
        run0(1'b0, n, rs);
        n_chk++;
        if (n != 20) begin
            n_fail++; $display("FAIL short_latency: done after %0d cycles, required 20", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        int n;
        bit rs;
        send_frame(1'b1, 1'b1, 0, 76, 1'b1);
        n_chk++;
        if (k0_0 !== ref_k0 || k1_0 !== ref_k1 || t0 !== ref_t || p0 !== ref_p || enc0 !== 1'b1) begin
            n_fail++; $display("FAIL stall_operands: T[31:0]=%0d P[127:96]=%0d enc=%b, required 64 75 1",
                               t0[31:0], p0[127:96], enc0);
        end
        run0(1'b1, n, rs);
        n_chk++;
        if (rs !== 1'b0 || n != 20) begin
            n_fail++; $display("FAIL stall_run_ready: s_ready seen=%b latency=%0d, required 0 and 20", rs, n);
        end
        @(posedge clk); #1;
        n_chk++;
        if (t0 !== ref_t || p0 !== ref_p || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL stall_no_consume: T[31:0]=%h busy=%b, required 00000040 and 0", t0[31:0], busy0);
        end
    endtask

    task automatic test_latency1;
        int n;
        bit rs;
        send_frame(1'b0, 1'b1, 300, 12, 1'b0);
        n_chk++;
        if ({start1, busy1, done1} !== 3'b110 || t1[31:0] !== 32'd300) begin
            n_fail++; $display("FAIL lat1_start: start,busy,done=%b T[31:0]=%0d, required 110 and 300", {start1, busy1, done1}, t1[31:0]);
        end
        @(posedge clk); #1;
        n_chk++;
        if ({start1, busy1, done1} !== 3'b011) begin
            n_fail++; $display("FAIL lat1_done: start,busy,done=%b, required 011", {start1, busy1, done1});
        end
        @(posedge clk); #1;
        n_chk++;
        if ({busy1, done1} !== 2'b00) begin
            n_fail++; $display("FAIL lat1_busy_len: busy,done=%b, required 00", {busy1, done1});
        end
        run0(1'b0, n, rs);
        n_chk++;
        if (n != 18) begin
            n_fail++; $display("FAIL lat20_concurrent: remaining %0d cycles, required 18", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load;
        send_frame(1'b1, 1'b1, 0, 50, 1'b0);
        if0.s_valid = 1'b1;
        if0.s_data  = 32'd50;
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({start0, busy0, done0, kv0, enc0, if0.s_ready} !== 6'b0 || (|k0_0) || (|k1_0) || (|t0) || (|p0)) begin
            n_fail++; $display("FAIL midload_reset: ctrl=%b K0[31:0]=%h, required all zero",
                               {start0, busy0, done0, kv0, enc0, if0.s_ready}, k0_0[31:0]);
        end
        rst = 1'b0;
        if0.s_valid = 1'b0;
    endtask

    task automatic test_forced_rekey;
        int n;
        bit rs;
        send_frame(1'b0, 1'b1, 0, 12, 1'b0);
        n_chk++;
        if ({start0, busy0, kv0} !== 3'b000) begin
            n_fail++; $display("FAIL forced_not_short: start,busy,key_valid=%b after 12 words, required 000", {start0, busy0, kv0});
        end
        send_frame(1'b0, 1'b1, 12, 64, 1'b0);
        n_chk++;
        if (start0 !== 1'b1 || kv0 !== 1'b1 || enc0 !== 1'b1) begin
            n_fail++; $display("FAIL forced_start: start,key_valid,enc=%b, required 111", {start0, kv0, enc0});
        end
        n_chk++;
        if (k0_0 !== ref_k0 || k1_0 !== ref_k1 || t0 !== ref_t || p0 !== ref_p) begin
            n_fail++; $display("FAIL forced_operands: K1[31:0]=%0d P[127:96]=%0d, required 40 and 75", k1_0[31:0], p0[127:96]);
        end
        run0(1'b0, n, rs);
        n_chk++;
        if (n != 20) begin
            n_fail++; $display("FAIL forced_latency: done after %0d cycles, required 20", n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst         = 1'b1;
        en1         = 1'b1;
        if0.s_valid = 1'b0;
        if0.s_data  = '0;
        if0.rekey   = 1'b0;
        if0.enc_in  = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_full_frame;
        test_short_frame;
        test_stall;
        test_latency1;
        test_reset_mid_load;
        test_forced_rekey;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
